conv_kernel_scheduler: RTL

//  Sequences one convolution stage: buffers NxN input windows in a FIFO and time-multiplexes

---
 rtl/conv_kernel_scheduler.sv | 121 ++++++++++++
 1 files changed

// File: rtl/conv_kernel_scheduler.sv
// Convolution stage scheduler: buffers NxN windows and issues each one to the PE lanes
// once per kernel group, handshaking lane results downstream with valid/ready.

module conv_lane_gate #(
    parameter int LANE = 0,
    parameter int PE   = 2,
    parameter int K    = 4,
    parameter int GW   = 2
) (
    input  logic [GW-1:0] pass_i,
    input  logic          active_i,
    output logic          en_o
);
    // Lane serves kernel pass*PE+LANE; lanes past the last kernel idle on the final pass.
    assign en_o = active_i && ((int'(pass_i) * PE + LANE) < K);
endmodule

module conv_kernel_scheduler #(
    parameter  int NumberOfK          = 4,
    parameter  int ProcessingElements = 2,
    parameter  int N                  = 3,
    parameter  int BitSize            = 8,
    parameter  int FifoDepth          = 4,
    localparam int CPP  = (NumberOfK + ProcessingElements - 1) / ProcessingElements,
    localparam int WinW = N * N * BitSize,
    localparam int GrpW = $clog2(CPP) + 1,
    localparam int CntW = $clog2(FifoDepth) + 1
) (
    input  logic                          clk_i,
    input  logic                          res_i,
    input  logic                          in_valid_i,
    input  logic [WinW-1:0]               in_data_i,
    output logic                          in_ready_o,
    output logic [WinW-1:0]               pe_data_o,
    output logic [GrpW-1:0]               pe_group_o,
    output logic [ProcessingElements-1:0] pe_mask_o,
    output logic                          out_valid_o,
    output logic                          out_last_o,
    input  logic                          out_ready_i,
    output logic [CntW-1:0]               fifo_count_o
);
    localparam int PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

    typedef enum logic {IDLE, ISSUE} state_e;

    state_e                          state_q, state_d;
    logic [GrpW-1:0]                 pass_q, pass_d;
    logic [PtrW-1:0]                 rd_q, rd_d, wr_q, wr_d;
    logic [CntW-1:0]                 cnt_q, cnt_d;
    logic [FifoDepth-1:0][WinW-1:0]  mem_q;
    logic                            issue, last, push, pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign issue      = (state_q == ISSUE);
    assign last       = (pass_q == GrpW'(CPP - 1));
    assign in_ready_o = (cnt_q < CntW'(FifoDepth));
    assign push       = in_valid_i && in_ready_o;
    assign pop        = issue && out_ready_i && last;

    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        if (issue && out_ready_i)
            pass_d = last ? '0 : pass_q + 1'b1;
        if (push) wr_d = ptr_inc(wr_q);
        if (pop)  rd_d = ptr_inc(rd_q);
        if (push && !pop)      cnt_d = cnt_q + 1'b1;
        else if (pop && !push) cnt_d = cnt_q - 1'b1;
        case (state_q)
            IDLE:    if (push) state_d = ISSUE;
            ISSUE:   if (cnt_d == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (res_i) begin
            state_q <= IDLE;
            pass_q  <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pass_q  <= pass_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage needs no reset: reads are gated by the issue state.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= in_data_i;
    end

    assign out_valid_o  = issue;
    assign out_last_o   = issue && last;
    assign pe_group_o   = issue ? pass_q : '0;
    assign pe_data_o    = issue ? mem_q[rd_q] : '0;
    assign fifo_count_o = cnt_q;

    for (genvar i = 0; i < ProcessingElements; i++) begin : g_lane
        conv_lane_gate #(
            .LANE (i),
            .PE   (ProcessingElements),
            .K    (NumberOfK),
            .GW   (GrpW)
        ) u_gate (
            .pass_i   (pass_q),
            .active_i (issue),
            .en_o     (pe_mask_o[i])
        );
    end
endmodule
